// File: rtl/hc165_reader_pkg.sv
// Shared definitions for the 74HC165 chain reader: FSM state encoding and
// the scan-length formula used to validate the scan period.
package hc165_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_SHIFT_LO = 3'd4,
        ST_DONE     = 3'd5
    } hc165_state_e;

    // Cycles from entering LOAD to leaving DONE for one complete scan.
    function automatic int scan_length(input int clk_div, input int num_bits);
        return 3 * clk_div + (num_bits - 1) * 2 * clk_div + 1;
    endfunction

endpackage

// File: rtl/hc165_reader_scan_tick_gen.sv
// Free-running scan period counter; emits a one-cycle start pulse every
// SCAN_PERIOD enabled cycles and is held at zero while disabled.
module hc165_reader_scan_tick_gen #(
    parameter int SCAN_PERIOD = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic start_o
);

    localparam int CNT_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        start_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            start_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hc165_reader.sv
// Periodically scans a chain of 74HC165 shift registers and presents the
// deserialised word (first bit out lands in the MSB) with valid/change pulses.
module hc165_reader
    import hc165_reader_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter int NUM_BITS    = 16,
    parameter int SCAN_PERIOD = 50000
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic                ser_in,
    output logic                sh_ld_n,
    output logic                srclk,
    output logic                clk_inh,
    output logic [NUM_BITS-1:0] par_data,
    output logic                data_valid,
    output logic                change_flag,
    output logic                busy
);

    localparam int SCAN_LEN = scan_length(CLK_DIV, NUM_BITS);
    localparam int PH_W     = $clog2(2 * CLK_DIV);
    localparam int BIT_W    = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

    localparam logic [PH_W-1:0]  PH_HALF_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LOAD_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(NUM_BITS - 1);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("hc165_reader: CLK_DIV must be at least 4");
    end
    if (SCAN_PERIOD <= SCAN_LEN) begin : g_bad_scan_period
        $error("hc165_reader: SCAN_PERIOD must exceed the scan length");
    end

    logic                scan_start;
    logic                ser_meta_q;
    logic                ser_sync_q;

    hc165_state_e        state_q,       state_d;
    logic [PH_W-1:0]     phase_q,       phase_d;
    logic [BIT_W-1:0]    bit_q,         bit_d;
    logic [NUM_BITS-1:0] shift_q,       shift_d;
    logic                sh_ld_n_q,     sh_ld_n_d;
    logic                srclk_q,       srclk_d;
    logic                clk_inh_q,     clk_inh_d;
    logic                busy_q,        busy_d;
    logic [NUM_BITS-1:0] par_data_q,    par_data_d;
    logic                data_valid_q,  data_valid_d;
    logic                change_flag_q, change_flag_d;

    hc165_reader_scan_tick_gen #(
        .SCAN_PERIOD(SCAN_PERIOD)
    ) u_tick (
        .clk_i  (sys_clk),
        .rst_n_i(rst_n),
        .en_i   (scan_en),
        .start_o(scan_start)
    );

    // QH comes straight off the board, so it crosses into sys_clk here.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ser_meta_q <= 1'b0;
            ser_sync_q <= 1'b0;
        end else begin
            ser_meta_q <= ser_in;
            ser_sync_q <= ser_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PH_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (scan_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (phase_q == PH_LOAD_LAST) begin
                    phase_d = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_q == PH_HALF_LAST) begin
                    phase_d = '0;
                    shift_d = {shift_q[NUM_BITS-2:0], ser_sync_q};
                    bit_d   = BIT_W'(1);
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_q == PH_HALF_LAST) begin
                    phase_d = '0;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                // Sampling late in the low phase gives the synchroniser time
                // to settle on the bit presented by the last rising edge.
                if (phase_q == PH_HALF_LAST) begin
                    phase_d = '0;
                    shift_d = {shift_q[NUM_BITS-2:0], ser_sync_q};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = ST_SHIFT_HI;
                    end
                end
            end
            ST_DONE: begin
                phase_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                phase_d = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Pin levels follow the state being entered so they line up with it.
        sh_ld_n_d     = (state_d != ST_LOAD);
        srclk_d       = (state_d == ST_SHIFT_HI);
        clk_inh_d     = !(state_d inside {ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO});
        busy_d        = (state_d != ST_IDLE);
        par_data_d    = par_data_q;
        data_valid_d  = 1'b0;
        change_flag_d = 1'b0;
        if (state_d == ST_DONE) begin
            par_data_d    = shift_d;
            data_valid_d  = 1'b1;
            change_flag_d = (shift_d != par_data_q);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            sh_ld_n_q     <= 1'b1;
            srclk_q       <= 1'b0;
            clk_inh_q     <= 1'b1;
            busy_q        <= 1'b0;
            par_data_q    <= '0;
            data_valid_q  <= 1'b0;
            change_flag_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            sh_ld_n_q     <= sh_ld_n_d;
            srclk_q       <= srclk_d;
            clk_inh_q     <= clk_inh_d;
            busy_q        <= busy_d;
            par_data_q    <= par_data_d;
            data_valid_q  <= data_valid_d;
            change_flag_q <= change_flag_d;
        end
    end

    assign sh_ld_n     = sh_ld_n_q;
    assign srclk       = srclk_q;
    assign clk_inh     = clk_inh_q;
    assign busy        = busy_q;
    assign par_data    = par_data_q;
    assign data_valid  = data_valid_q;
    assign change_flag = change_flag_q;

endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader driving a behavioural pair of 74HC165 devices and
// checking each scan against the word presented on their parallel inputs.
module tb_hc165_reader;

    localparam int CLK_DIV     = 4;
    localparam int NUM_BITS    = 16;
    localparam int SCAN_PERIOD = 200;
    localparam int SCAN_LEN    = 133;

    logic        sysClk = 1'b0;
    logic        rstN   = 1'b0;
    logic        scanEn = 1'b0;
    logic        serIn;
    logic        shLdN;
    logic        srclk;
    logic        clkInh;
    logic [15:0] parData;
    logic        dataValid;
    logic        changeFlag;
    logic        busy;

    int total   = 0;
    int bad     = 0;
    int cycleNo = 0;
    int relCyc  = 0;
    int prevDv  = 0;

    logic [15:0] pattern = 16'h0000;
    logic [15:0] chain   = 16'h0000;
    logic [15:0] expWord = 16'h0000;

    hc165_reader #(
        .CLK_DIV    (CLK_DIV),
        .NUM_BITS   (NUM_BITS),
        .SCAN_PERIOD(SCAN_PERIOD)
    ) dut (
        .sys_clk    (sysClk),
        .rst_n      (rstN),
        .scan_en    (scanEn),
        .ser_in     (serIn),
        .sh_ld_n    (shLdN),
        .srclk      (srclk),
        .clk_inh    (clkInh),
        .par_data   (parData),
        .data_valid (dataValid),
        .change_flag(changeFlag),
        .busy       (busy)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) cycleNo <= cycleNo + 1;

    // Two cascaded HC165s: parallel load while SH/LD low, shift toward QH on CLK rise.
    always @(negedge shLdN or posedge srclk) begin
        if (shLdN === 1'b0) chain = pattern;
        else if (clkInh === 1'b0) chain = {chain[14:0], 1'b0};
    end
    assign serIn = chain[15];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Waits for the next LOAD and records the pin activity of that scan.
    task automatic measure_scan(input int dropAt, output int loadCyc, output int ldLow,
                                output int inhLow, output int edges, output int badHi,
                                output int busyCyc, output int dvCnt, output int dvCyc,
                                output logic [15:0] pdAtDv, output logic cfAtDv,
                                output logic timedOut);
        int waited = 0;
        int idx    = 0;
        int hiRun  = 0;
        logic prevSr = 1'b0;
        loadCyc = 0; ldLow = 0; inhLow = 0; edges = 0; badHi = 0;
        busyCyc = 0; dvCnt = 0; dvCyc = 0; pdAtDv = 16'h0; cfAtDv = 1'b0;
        timedOut = 1'b0;
        do begin
            @(negedge sysClk);
            waited++;
        end while (shLdN !== 1'b0 && waited < 400);
        if (shLdN !== 1'b0) begin
            timedOut = 1'b1;
            return;
        end
        loadCyc = cycleNo;
        while (busy === 1'b1 && idx < 300) begin
            if (idx == dropAt) scanEn = 1'b0;
            busyCyc++;
            if (shLdN === 1'b0) ldLow++;
            if (clkInh === 1'b0) inhLow++;
            if (srclk === 1'b1 && !prevSr) edges++;
            if (srclk === 1'b1) hiRun++;
            if (srclk !== 1'b1 && prevSr) begin
                if (hiRun != CLK_DIV) badHi++;
                hiRun = 0;
            end
            prevSr = (srclk === 1'b1);
            if (dataValid === 1'b1) begin
                dvCnt++;
                dvCyc  = cycleNo;
                pdAtDv = parData;
                cfAtDv = changeFlag;
            end
            @(negedge sysClk);
            idx++;
        end
        if (idx >= 300) timedOut = 1'b1;
    endtask

    task automatic test_reset();
        int lowSeen = 0;
        rstN   = 1'b0;
        scanEn = 1'b1;
        pattern = 16'hA5C3;
        repeat (10) begin
            @(negedge sysClk);
            if (shLdN !== 1'b1) lowSeen++;
        end
        total++; if (lowSeen !== 0) begin bad++; $display("[TB] FAIL reset_no_load: got %0d low cycles, expected 0", lowSeen); end
        total++; if (shLdN !== 1'b1) begin bad++; $display("[TB] FAIL reset_sh_ld_n: got %b expected 1", shLdN); end
        total++; if (srclk !== 1'b0) begin bad++; $display("[TB] FAIL reset_srclk: got %b expected 0", srclk); end
        total++; if (clkInh !== 1'b1) begin bad++; $display("[TB] FAIL reset_clk_inh: got %b expected 1", clkInh); end
        total++; if (parData !== 16'h0) begin bad++; $display("[TB] FAIL reset_par_data: got %h expected 0000", parData); end
        total++; if (dataValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_valid: got %b expected 0", dataValid); end
        total++; if (changeFlag !== 1'b0) begin bad++; $display("[TB] FAIL reset_change_flag: got %b expected 0", changeFlag); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rstN    = 1'b1;
        relCyc  = cycleNo;
        expWord = 16'h0;
    endtask

    task automatic test_first_scan();
        int lc, ll, il, ed, bh, bc, dc, dy;
        logic [15:0] pd;
        logic cf, to;
        measure_scan(-1, lc, ll, il, ed, bh, bc, dc, dy, pd, cf, to);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL first_timeout: scan not observed within bound"); end
        total++; if (lc - relCyc != SCAN_PERIOD) begin bad++; $display("[TB] FAIL first_latency: got %0d expected %0d", lc - relCyc, SCAN_PERIOD); end
        total++; if (ll != 2 * CLK_DIV) begin bad++; $display("[TB] FAIL first_load_len: got %0d expected %0d", ll, 2 * CLK_DIV); end
        total++; if (ed != NUM_BITS - 1) begin bad++; $display("[TB] FAIL first_edges: got %0d expected %0d", ed, NUM_BITS - 1); end
        total++; if (bh != 0) begin bad++; $display("[TB] FAIL first_high_len: got %0d bad high phases expected 0", bh); end
        total++; if (il != CLK_DIV + (NUM_BITS - 1) * 2 * CLK_DIV) begin bad++; $display("[TB] FAIL first_inh_low: got %0d expected %0d", il, CLK_DIV + (NUM_BITS - 1) * 2 * CLK_DIV); end
        total++; if (bc != SCAN_LEN) begin bad++; $display("[TB] FAIL first_busy_len: got %0d expected %0d", bc, SCAN_LEN); end
        total++; if (dc != 1) begin bad++; $display("[TB] FAIL first_dv_count: got %0d expected 1", dc); end
        total++; if (pd !== 16'hA5C3) begin bad++; $display("[TB] FAIL first_par_data: got %h expected a5c3", pd); end
        total++; if (cf !== 1'b1) begin bad++; $display("[TB] FAIL first_change: got %b expected 1", cf); end
        expWord = 16'hA5C3;
        prevDv  = dy;
    endtask

    task automatic test_repeat_scan();
        int lc, ll, il, ed, bh, bc, dc, dy;
        logic [15:0] pd;
        logic cf, to;
        for (int i = 0; i < 2; i++) begin
            measure_scan(-1, lc, ll, il, ed, bh, bc, dc, dy, pd, cf, to);
            total++; if (to !== 1'b0 || dc != 1) begin bad++; $display("[TB] FAIL repeat_dv: got %0d pulses timeout=%b expected 1", dc, to); end
            total++; if (dy - prevDv != SCAN_PERIOD) begin bad++; $display("[TB] FAIL repeat_period: got %0d expected %0d", dy - prevDv, SCAN_PERIOD); end
            total++; if (pd !== 16'hA5C3) begin bad++; $display("[TB] FAIL repeat_par_data: got %h expected a5c3", pd); end
            total++; if (cf !== 1'b0) begin bad++; $display("[TB] FAIL repeat_change: got %b expected 0", cf); end
            total++; if (parData !== 16'hA5C3) begin bad++; $display("[TB] FAIL repeat_hold: got %h expected a5c3", parData); end
            prevDv = dy;
        end
    endtask

    task automatic test_pattern_change();
        int lc, ll, il, ed, bh, bc, dc, dy;
        logic [15:0] pd;
        logic cf, to;
        pattern = 16'h0001;
        measure_scan(-1, lc, ll, il, ed, bh, bc, dc, dy, pd, cf, to);
        total++; if (to !== 1'b0 || dc != 1) begin bad++; $display("[TB] FAIL change_dv: got %0d pulses timeout=%b expected 1", dc, to); end
        total++; if (pd !== 16'h0001) begin bad++; $display("[TB] FAIL change_par_data: got %h expected 0001", pd); end
        total++; if (cf !== 1'b1) begin bad++; $display("[TB] FAIL change_flag: got %b expected 1", cf); end
        expWord = 16'h0001;
        prevDv  = dy;
    endtask

    task automatic test_random();
        int lc, ll, il, ed, bh, bc, dc, dy;
        logic [15:0] pd;
        logic cf, to, expCf;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) pattern = 16'hFFFF;
            else if (i == 1) pattern = 16'h0000;
            else if (i == 3) pattern = pattern;
            else pattern = 16'($urandom);
            expCf = (pattern != expWord);
            measure_scan(-1, lc, ll, il, ed, bh, bc, dc, dy, pd, cf, to);
            total++; if (to !== 1'b0 || dc != 1) begin bad++; $display("[TB] FAIL random_dv[%0d]: got %0d pulses timeout=%b expected 1", i, dc, to); end
            total++; if (pd !== pattern) begin bad++; $display("[TB] FAIL random_par_data[%0d]: got %h expected %h", i, pd, pattern); end
            total++; if (cf !== expCf) begin bad++; $display("[TB] FAIL random_change[%0d]: got %b expected %b", i, cf, expCf); end
            total++; if (dy - prevDv != SCAN_PERIOD) begin bad++; $display("[TB] FAIL random_period[%0d]: got %0d expected %0d", i, dy - prevDv, SCAN_PERIOD); end
            expWord = pattern;
            prevDv  = dy;
        end
    endtask

    task automatic test_scan_en_drop();
        int lc, ll, il, ed, bh, bc, dc, dy;
        int lowSeen = 0;
        logic [15:0] pd;
        logic cf, to, expCf;
        pattern = 16'($urandom);
        expCf   = (pattern != expWord);
        measure_scan(50, lc, ll, il, ed, bh, bc, dc, dy, pd, cf, to);
        total++; if (to !== 1'b0 || dc != 1) begin bad++; $display("[TB] FAIL drop_dv: got %0d pulses timeout=%b expected 1", dc, to); end
        total++; if (bc != SCAN_LEN) begin bad++; $display("[TB] FAIL drop_busy_len: got %0d expected %0d", bc, SCAN_LEN); end
        total++; if (pd !== pattern) begin bad++; $display("[TB] FAIL drop_par_data: got %h expected %h", pd, pattern); end
        total++; if (cf !== expCf) begin bad++; $display("[TB] FAIL drop_change: got %b expected %b", cf, expCf); end
        expWord = pattern;
        repeat (1000) begin
            @(negedge sysClk);
            if (shLdN !== 1'b1 || busy !== 1'b0) lowSeen++;
        end
        total++; if (lowSeen != 0) begin bad++; $display("[TB] FAIL drop_no_scan: got %0d active cycles expected 0", lowSeen); end
    endtask

    task automatic test_reset_mid_scan();
        int lc, ll, il, ed, bh, bc, dc, dy;
        int waited = 0;
        logic [15:0] pd;
        logic cf, to;
        pattern = 16'($urandom) | 16'h0100;
        scanEn  = 1'b1;
        while (srclk !== 1'b1 && waited < 500) begin
            @(negedge sysClk);
            waited++;
        end
        total++; if (srclk !== 1'b1) begin bad++; $display("[TB] FAIL midrst_wait: srclk high not seen within %0d cycles", waited); end
        rstN = 1'b0;
        @(negedge sysClk);
        total++; if (srclk !== 1'b0) begin bad++; $display("[TB] FAIL midrst_srclk: got %b expected 0", srclk); end
        total++; if (shLdN !== 1'b1) begin bad++; $display("[TB] FAIL midrst_sh_ld_n: got %b expected 1", shLdN); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        total++; if (parData !== 16'h0) begin bad++; $display("[TB] FAIL midrst_par_data: got %h expected 0000", parData); end
        total++; if (clkInh !== 1'b1) begin bad++; $display("[TB] FAIL midrst_clk_inh: got %b expected 1", clkInh); end
        rstN    = 1'b1;
        relCyc  = cycleNo;
        expWord = 16'h0;
        measure_scan(-1, lc, ll, il, ed, bh, bc, dc, dy, pd, cf, to);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL midrst_timeout: scan not observed within bound"); end
        total++; if (lc - relCyc != SCAN_PERIOD) begin bad++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", lc - relCyc, SCAN_PERIOD); end
        total++; if (pd !== pattern) begin bad++; $display("[TB] FAIL midrst_par_data: got %h expected %h", pd, pattern); end
        total++; if (cf !== 1'b1) begin bad++; $display("[TB] FAIL midrst_change: got %b expected 1", cf); end
    endtask

    initial begin
        $display("[TB] starting hc165_reader bench");
        test_reset();
        test_first_scan();
        test_repeat_scan();
        test_pattern_change();
        test_random();
        test_scan_en_drop();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
